// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines x 4 words (16 B/line).
// Hits return INSTRUCTION combinationally with BUSYWAIT low. A miss raises
// BUSYWAIT, latches the line address and refills it from memory through a
// MEM_READ / MEM_BUSYWAIT handshake.
//
// Ports:
//   CLK           system clock, state updates on posedge
//   RESET         asynchronous active-low reset
//   PC            fetch address (PC[3:2] word, PC[6:4] index, PC[31:7] tag)
//   INSTRUCTION   word for PC, meaningful only while BUSYWAIT is low
//   BUSYWAIT      stall request to the PC and IF/ID registers
//   MEM_READ      line read request to instruction memory
//   MEM_ADDRESS   line address of the pending miss (PC[31:4])
//   MEM_READDATA  refill line, word n at bits [32n+31:32n]
//   MEM_BUSYWAIT  memory busy; low during READ marks the data cycle
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e       state_q, state_d;
  logic [27:0]  miss_addr_q, miss_addr_d;
  logic [7:0]   valid_q;
  logic [24:0]  tag_q  [8];
  logic [127:0] data_q [8];

  logic [2:0]   idx;
  logic [6:0]   bit_off;
  logic         hit;
  logic         fill_en;

  assign idx     = PC[6:4];
  assign bit_off = {PC[3:2], 5'd0};
  assign hit     = valid_q[idx] && (tag_q[idx] == PC[31:7]);
  // Fill only in the data cycle; reset keeps the FSM in StIdle so a partial
  // fill is dropped without touching the arrays.
  assign fill_en = RESET && (state_q == StRead) && !MEM_BUSYWAIT;

  // State register, miss address and valid bits.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      miss_addr_q <= 28'd0;
      valid_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) begin
        valid_q[miss_addr_q[2:0]] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[miss_addr_q[2:0]]  <= miss_addr_q[27:3];
      data_q[miss_addr_q[2:0]] <= MEM_READDATA;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          miss_addr_d = PC[31:4];
          state_d     = StRead;
        end
      end
      StRead: begin
        if (!MEM_BUSYWAIT) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; all forced low while reset is held.
  always_comb begin
    INSTRUCTION = 32'd0;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = 28'd0;
    if (RESET) begin
      INSTRUCTION = data_q[idx][bit_off +: 32];
      MEM_ADDRESS = miss_addr_q;
      unique case (state_q)
        StIdle: BUSYWAIT = !hit;
        StRead: begin
          BUSYWAIT = 1'b1;
          MEM_READ = 1'b1;
        end
        default: BUSYWAIT = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Memory contents: two directed lines, everything else a hash of the address.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    logic [27:0] la;
    logic [1:0]  w;
    la = wa[29:2];
    w  = wa[1:0];
    if (la == 28'h2) return 32'h11 + 32'h11 * 32'(w);
    if (la == 28'hA) return 32'hA + 32'(w);
    return ({wa, 2'b00} ^ 32'h5A3C_9671) + {wa[7:0], 24'h0};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    for (int n = 0; n < 4; n++) l[32*n +: 32] = mem_word({la, 2'(n)});
    return l;
  endfunction

  // Memory model: busy for L cycles after MEM_READ rises, then one data cycle.
  int L = 4;
  int mem_cnt = 0;
  assign MEM_BUSYWAIT = MEM_READ ? (mem_cnt != L) : 1'b0;
  assign MEM_READDATA = mem_line(MEM_ADDRESS);
  always @(posedge CLK) begin
    if (MEM_READ && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
    else                          mem_cnt <= 0;
  end

  // Reference cache: which tag each index holds, if any.
  bit          mv [8];
  logic [24:0] mt [8];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          stall;
    int          nfills;
    logic [27:0] line0;
    logic [27:0] line1;
  } item_t;
  item_t q[$];

  function automatic bit model_access(input logic [31:0] pc);
    bit h;
    h = mv[pc[6:4]] && (mt[pc[6:4]] == pc[31:7]);
    mv[pc[6:4]] = 1'b1;
    mt[pc[6:4]] = pc[31:7];
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles and fills, checks on every accepted fetch.
  bit mon_en = 1'b0;
  int busy_cnt = 0;
  int fill_idx = 0;
  bit prev_mr = 1'b0;
  always @(negedge CLK) begin
    if (!mon_en) begin
      busy_cnt = 0;
      fill_idx = 0;
      prev_mr  = 1'b0;
    end else if (RESET) begin
      if (prev_mr && !MEM_READ) fill_idx++;
      prev_mr = MEM_READ;
      if (MEM_READ && q.size() > 0)
        chk("mem_address", 32'(MEM_ADDRESS),
            32'((fill_idx == 0) ? q[0].line0 : q[0].line1));
      if (BUSYWAIT) begin
        busy_cnt++;
      end else if (q.size() > 0) begin
        item_t it;
        it = q.pop_front();
        chk($sformatf("instr pc=%h", it.pc), INSTRUCTION, it.instr);
        chk($sformatf("stall pc=%h", it.pc), 32'(busy_cnt), 32'(it.stall));
        chk($sformatf("fills pc=%h", it.pc), 32'(fill_idx), 32'(it.nfills));
        busy_cnt = 0;
        fill_idx = 0;
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL timeout: BUSYWAIT still high after %0d cycles, expected low", n);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1: present pc, queue the expected outcome, wait for acceptance.
  task automatic fetch(input logic [31:0] pc);
    item_t it;
    bit h;
    PC = pc;
    h = model_access(pc);
    it.pc = pc;
    it.instr = mem_word(pc[31:2]);
    it.stall = h ? 0 : L + 2;
    it.nfills = h ? 0 : 1;
    it.line0 = pc[31:4];
    it.line1 = 28'd0;
    q.push_back(it);
    wait_accept();
  endtask

  // Miss on pc1, switch PC to pc2 after k posedges while the fill is in flight.
  task automatic fetch_switch(input logic [31:0] pc1, input logic [31:0] pc2, input int k);
    item_t it;
    bit h1, h2;
    PC = pc1;
    h1 = model_access(pc1);
    h2 = model_access(pc2);
    it.pc = pc2;
    it.instr = mem_word(pc2[31:2]);
    it.stall = (h1 ? 0 : L + 2) + (h2 ? 0 : L + 2);
    it.nfills = (h1 ? 0 : 1) + (h2 ? 0 : 1);
    it.line0 = h1 ? pc2[31:4] : pc1[31:4];
    it.line1 = pc2[31:4];
    q.push_back(it);
    repeat (k) @(posedge CLK);
    #1;
    PC = pc2;
    wait_accept();
  endtask

  initial begin
    RESET = 1'b0;
    PC = 32'h20;
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;

    repeat (3) begin
      @(negedge CLK);
      chk("rst busywait", 32'(BUSYWAIT), 32'd0);
      chk("rst mem_read", 32'(MEM_READ), 32'd0);
      chk("rst mem_address", 32'(MEM_ADDRESS), 32'd0);
      chk("rst instruction", INSTRUCTION, 32'd0);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("cold miss busywait", 32'(BUSYWAIT), 32'd1);
    mon_en = 1'b1;

    L = 4;
    fetch(32'h20);
    fetch(32'h24);
    fetch(32'h28);
    fetch(32'h2C);
    fetch(32'hA0);
    fetch(32'h20);

    // Reset in the 2nd READ cycle of a miss on 0xA0.
    mon_en = 1'b0;
    PC = 32'hA0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("midfill mem_read", 32'(MEM_READ), 32'd0);
    chk("midfill busywait", 32'(BUSYWAIT), 32'd0);
    chk("midfill mem_address", 32'(MEM_ADDRESS), 32'd0);
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    mon_en = 1'b1;
    fetch(32'h20);

    // PC change during a refill of 0x20.
    fetch(32'hA0);
    fetch_switch(32'h20, 32'h40, 2);
    fetch(32'h20);

    // Random traffic over four tags to mix hits, conflicts and latencies.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
           ($urandom_range(0, 3) << 2);
      L = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) begin
        logic [31:0] pc2;
        pc2 = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4);
        if (mv[pc[6:4]] && mt[pc[6:4]] == pc[31:7]) fetch(pc);
        else fetch_switch(pc, pc2, $urandom_range(1, L));
      end else begin
        fetch(pc);
      end
    end

    mon_en = 1'b0;
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the fetch-stage PC and the 128-bit-line instruction memory. It returns the 32-bit instruction for the current PC in the same cycle on a hit. On a miss it raises BUSYWAIT, which stalls the PC register and the IF/ID pipeline register, and refills the line from memory through a read/busywait handshake. It is the producer of the BUSYWAIT signal that the IF/ID register consumes.

## Interface
- No parameters: geometry fixed at 8 lines × 4 words (16 B/line). Address split: PC[1:0] ignored, PC[3:2] word offset, PC[6:4] index, PC[31:7] tag (25 b).
- CLK  input  1  system clock, all state updates on posedge
- RESET  input  1  asynchronous, active-low reset
- PC  input  32  fetch address from the PC register
- INSTRUCTION  output  32  instruction word for PC; meaningful only while BUSYWAIT=0
- BUSYWAIT  output  1  stall request to PC and IF/ID register
- MEM_READ  output  1  line read request to instruction memory
- MEM_ADDRESS  output  28  line address (miss PC[31:4])
- MEM_READDATA  input  128  refill line, word n at bits [32n+31:32n]
- MEM_BUSYWAIT  input  1  memory busy; low during a READ cycle means MEM_READDATA is valid

## Operation
- Storage: 8 × {valid, tag[24:0], data[127:0]}.
- hit = valid[PC[6:4]] && tag[PC[6:4]] == PC[31:7].
- INSTRUCTION: combinational select of word PC[3:2] from line PC[6:4], independent of hit. Forced to 0 while RESET is low.
- FSM states: IDLE, READ.
- IDLE:
  - BUSYWAIT = !hit (combinational). MEM_READ = 0.
  - On a posedge with !hit: latch PC[31:4] into the miss-address register, then go to READ.
- READ:
  - BUSYWAIT = 1. MEM_READ = 1. MEM_ADDRESS = miss-address register.
  - On a posedge with MEM_BUSYWAIT = 0:
    - write MEM_READDATA into line missaddr[2:0];
    - set tag to missaddr[27:3] and valid to 1;
    - go to IDLE.
  - On a posedge with MEM_BUSYWAIT = 1: stay in READ.
- Memory contract: the memory asserts MEM_BUSYWAIT in the same cycle MEM_READ first rises. The first READ cycle in which MEM_BUSYWAIT is low is the data cycle.
- MEM_ADDRESS holds its last value in IDLE and is 0 after reset.
- PC changes during READ are ignored. The fill completes for the latched address, and IDLE then re-evaluates hit for the current PC.
- No write path. No write-back. Replacement on a conflict overwrites the line unconditionally.
- Reset (RESET low, asynchronous):
  - all valid bits cleared, state forced to IDLE, miss-address register cleared to 0;
  - while RESET is low: BUSYWAIT = 0, MEM_READ = 0, MEM_ADDRESS = 0, INSTRUCTION = 0.
  - Tag and data arrays are not cleared.
  - After release the first fetch misses.

## Timing
- Hit latency: 0 cycles. INSTRUCTION is valid combinationally before the next posedge, and BUSYWAIT stays low.
- Miss, for a memory that holds MEM_BUSYWAIT high for L cycles after MEM_READ rises:
  - cycle 0: IDLE, BUSYWAIT high.
  - cycles 1..L+1: READ.
  - fill takes place on the posedge ending cycle L+1.
  - cycle L+2: IDLE hit, BUSYWAIT low.
  - Total stall: L+2 cycles (PC held for L+2 posedges).
- MEM_READ rises on the posedge after miss detection. It falls on the fill posedge and is never asserted in IDLE.
- A second miss can begin in the cycle right after a fill: IDLE detects the new miss, and READ is re-entered on the next posedge.
- RESET asserted during READ: MEM_READ drops immediately (asynchronously). The partial fill is discarded and no array write occurs.

## Test plan
- Reset: hold RESET=0 for 3 cycles with PC=0x00000020. Required: BUSYWAIT=0, MEM_READ=0, MEM_ADDRESS=0, INSTRUCTION=0 throughout.
- Cold miss: after reset, PC=0x00000020; memory model with L=4 returns line {0x44,0x33,0x22,0x11}. Required:
  - BUSYWAIT=1 immediately;
  - MEM_READ=1 with MEM_ADDRESS=0x0000002 from the next posedge;
  - BUSYWAIT low after exactly 6 posedges, with INSTRUCTION=0x11.
- Hits: PC=0x24, 0x28, 0x2C on consecutive cycles. Required: BUSYWAIT=0 every cycle, MEM_READ never asserted, INSTRUCTION=0x22, 0x33, 0x44.
- Conflict miss: PC=0x000000A0 (index 2, different tag), memory returns {0xD,0xC,0xB,0xA}. Required:
  - miss with MEM_ADDRESS=0x000000A, then INSTRUCTION=0xA;
  - afterwards PC=0x20 misses again with MEM_ADDRESS=0x0000002.
- Reset mid-fill: drive RESET=0 in the 2nd READ cycle. Required:
  - MEM_READ=0 and BUSYWAIT=0 immediately;
  - after release, PC=0x20 misses (valid cleared).
- PC change mid-fill: during a refill for 0x20, change PC to 0x40. Required:
  - MEM_ADDRESS stays 0x0000002 until the fill completes;
  - next cycle, a miss on 0x40 with MEM_ADDRESS=0x0000004;
  - afterwards PC=0x20 hits.
